// File: rtl/store_write_buffer_pkg.sv
// Shared sizing defaults for the store write buffer and the data memory it fronts,
// plus the memory-port arbitration encoding.
package store_write_buffer_pkg;

    localparam int SWB_DATA_BITS = 32;
    localparam int SWB_ADDR_BITS = 32;
    localparam int SWB_DEPTH     = 4;
    localparam int SWB_PTR_BITS  = 2;

    // Who owns the single data-memory port this cycle
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_sel_e;

endpackage

// File: rtl/store_fwd_match.sv
// Load-to-store forwarding: finds the youngest valid buffered store whose address
// equals the load address, scanning by age from head (oldest) towards tail.
module store_fwd_match
    import store_write_buffer_pkg::*;
#(
    parameter int DATA_BITS = SWB_DATA_BITS,
    parameter int ADDR_BITS = SWB_ADDR_BITS,
    parameter int DEPTH     = SWB_DEPTH,
    parameter int PTR_BITS  = SWB_PTR_BITS
) (
    input  logic [DEPTH-1:0][ADDR_BITS-1:0] i_entry_addr,
    input  logic [DEPTH-1:0][DATA_BITS-1:0] i_entry_data,
    input  logic [DEPTH-1:0]                i_entry_valid,
    input  logic [PTR_BITS-1:0]             i_head,
    input  logic [ADDR_BITS-1:0]            i_ld_addr,
    output logic                            o_hit,
    output logic [DATA_BITS-1:0]            o_data
);

    logic [DEPTH-1:0]    w_match;
    logic [PTR_BITS-1:0] w_idx [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = i_entry_valid[gi] && (i_entry_addr[gi] == i_ld_addr);
            // w_idx[k] is the physical slot holding the k-th oldest entry
            assign w_idx[gi]   = i_head + PTR_BITS'(gi);
        end
    endgenerate

    // Later (younger) matches override earlier ones
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[w_idx[k]]) begin
                o_hit  = 1'b1;
                o_data = i_entry_data[w_idx[k]];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the MEM stage and data memory: loads own the port,
// stores drain one per load-free cycle, and loads forward from queued stores.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DATA_BITS = SWB_DATA_BITS,
    parameter int ADDR_BITS = SWB_ADDR_BITS,
    parameter int DEPTH     = SWB_DEPTH,
    parameter int PTR_BITS  = SWB_PTR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stWrite,
    input  logic [ADDR_BITS-1:0] stAddr,
    input  logic [DATA_BITS-1:0] stData,
    input  logic                 ldRead,
    input  logic [ADDR_BITS-1:0] ldAddr,
    output logic [DATA_BITS-1:0] ldData,
    output logic                 bufFull,
    output logic                 bufEmpty,
    output logic                 errOverflow,
    output logic [ADDR_BITS-1:0] memAddress,
    output logic [DATA_BITS-1:0] memWriteData,
    output logic                 memWrite,
    output logic                 memRead,
    input  logic [DATA_BITS-1:0] readDataMem
);

    localparam logic [PTR_BITS:0]   C_DEPTH   = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0]   C_CNT_ONE = 1;
    localparam logic [PTR_BITS-1:0] C_PTR_ONE = 1;

    logic [ADDR_BITS-1:0] r_addr [DEPTH];
    logic [DATA_BITS-1:0] r_data [DEPTH];
    logic [PTR_BITS-1:0]  r_head;
    logic [PTR_BITS-1:0]  r_tail;
    logic [PTR_BITS:0]    r_count;
    logic                 r_overflow;

    logic                           w_full;
    logic                           w_empty;
    logic                           w_push;
    logic                           w_drain;
    logic [DEPTH-1:0]               w_valid;
    logic [DEPTH-1:0][ADDR_BITS-1:0] w_entry_addr;
    logic [DEPTH-1:0][DATA_BITS-1:0] w_entry_data;
    logic                           w_fwd_hit;
    logic [DATA_BITS-1:0]           w_fwd_data;
    port_sel_e                      w_port_sel;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    // Full is judged on registered count, so a same-cycle drain never frees a slot for a push
    assign w_push  = stWrite && !w_full;
    assign w_drain = !w_empty && !ldRead && !reset;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_BITS-1:0] w_age;
            assign w_age            = PTR_BITS'(gi) - r_head;
            assign w_valid[gi]      = ({1'b0, w_age} < r_count);
            assign w_entry_addr[gi] = r_addr[gi];
            assign w_entry_data[gi] = r_data[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= stAddr;
            r_data[r_tail] <= stData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + C_PTR_ONE;
            end
            if (w_drain) begin
                r_head <= r_head + C_PTR_ONE;
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (stWrite && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    store_fwd_match #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS),
        .DEPTH     (DEPTH),
        .PTR_BITS  (PTR_BITS)
    ) u_fwd (
        .i_entry_addr  (w_entry_addr),
        .i_entry_data  (w_entry_data),
        .i_entry_valid (w_valid),
        .i_head        (r_head),
        .i_ld_addr     (ldAddr),
        .o_hit         (w_fwd_hit),
        .o_data        (w_fwd_data)
    );

    always_comb begin
        w_port_sel = PORT_IDLE;
        if (ldRead) begin
            w_port_sel = PORT_LOAD;
        end else if (w_drain) begin
            w_port_sel = PORT_DRAIN;
        end
    end

    assign memRead      = ldRead;
    assign memWrite     = (w_port_sel == PORT_DRAIN);
    assign memAddress   = (w_port_sel == PORT_DRAIN) ? r_addr[r_head] : ldAddr;
    assign memWriteData = r_data[r_head];
    assign ldData       = w_fwd_hit ? w_fwd_data : readDataMem;
    assign bufFull      = w_full;
    assign bufEmpty     = w_empty;
    assign errOverflow  = r_overflow;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drives on negedge, checks #1 later,
// models the data memory and logs every memory write.
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stWrite = 1'b0;
    logic [31:0] stAddr = '0;
    logic [31:0] stData = '0;
    logic        ldRead = 1'b0;
    logic [31:0] ldAddr = '0;
    logic [31:0] ldData;
    logic        bufFull;
    logic        bufEmpty;
    logic        errOverflow;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readDataMem;

    always #5 clk = ~clk;

    store_write_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .stWrite      (stWrite),
        .stAddr       (stAddr),
        .stData       (stData),
        .ldRead       (ldRead),
        .ldAddr       (ldAddr),
        .ldData       (ldData),
        .bufFull      (bufFull),
        .bufEmpty     (bufEmpty),
        .errOverflow  (errOverflow),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memRead      (memRead),
        .readDataMem  (readDataMem)
    );

    // Memory model: unwritten words read back as {addr[15:0], ~addr[15:0]}
    logic [31:0] mem [0:4095];
    bit          mem_valid [0:4095];
    logic [31:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    int          wlog_cyc  [$];
    int          cyc = 0;
    int          n_illegal = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    assign readDataMem = mem_valid[memAddress[11:0]] ? mem[memAddress[11:0]]
                                                     : {memAddress[15:0], ~memAddress[15:0]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memWrite) begin
            mem[memAddress[11:0]]       <= memWriteData;
            mem_valid[memAddress[11:0]] <= 1'b1;
            wlog_addr.push_back(memAddress);
            wlog_data.push_back(memWriteData);
            wlog_cyc.push_back(cyc);
        end
        if (!reset && ldRead && stWrite) begin
            n_illegal <= n_illegal + 1;
            $display("note: load and store issued together at cycle %0d", cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] sa, input logic [31:0] sd,
                         input logic ld, input logic [31:0] la);
        @(negedge clk);
        stWrite = st;
        stAddr  = sa;
        stData  = sd;
        ldRead  = ld;
        ldAddr  = la;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        stWrite = 1'b0;
        ldRead  = 1'b0;
        ldAddr  = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
    endtask

    task automatic drain_wait(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bufEmpty) break;
            idle();
        end
        chk(tag, 32'(bufEmpty), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, three stores drain on consecutive cycles in order
        do_reset();
        chk("rst_empty", 32'(bufEmpty), 32'h1);
        chk("rst_full", 32'(bufFull), 32'h0);
        chk("rst_memwrite", 32'(memWrite), 32'h0);
        chk("rst_overflow", 32'(errOverflow), 32'h0);
        chk("rst_memread", 32'(memRead), 32'h0);
        clear_log();
        drive(1'b1, 32'h10, 32'h11111111, 1'b0, 32'h0);
        drive(1'b1, 32'h14, 32'h22222222, 1'b0, 32'h0);
        drive(1'b1, 32'h18, 32'h33333333, 1'b0, 32'h0);
        idle();
        idle();
        chk("t1_empty", 32'(bufEmpty), 32'h1);
        chk("t1_nwrites", wlog_addr.size(), 32'd3);
        if (wlog_addr.size() == 3) begin
            chk("t1_addr0", wlog_addr[0], 32'h10);
            chk("t1_data0", wlog_data[0], 32'h11111111);
            chk("t1_addr1", wlog_addr[1], 32'h14);
            chk("t1_data1", wlog_data[1], 32'h22222222);
            chk("t1_addr2", wlog_addr[2], 32'h18);
            chk("t1_data2", wlog_data[2], 32'h33333333);
            chk("t1_consec1", wlog_cyc[1] - wlog_cyc[0], 32'd1);
            chk("t1_consec2", wlog_cyc[2] - wlog_cyc[1], 32'd1);
        end

        // 2: loads hold the port while four stores fill the buffer, fifth overflows
        do_reset();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'h50000000 + 32'(i), 1'b1, 32'h40);
            chk("t2_ld_mem", ldData, 32'h0040FFBF);
            chk("t2_nowrite", 32'(memWrite), 32'h0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        chk("t2_full", 32'(bufFull), 32'h1);
        chk("t2_memread", 32'(memRead), 32'h1);
        chk("t2_memaddr", memAddress, 32'h40);
        chk("t2_ovf_before", 32'(errOverflow), 32'h0);
        drive(1'b1, 32'h200, 32'h99999999, 1'b1, 32'h40);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        chk("t2_overflow", 32'(errOverflow), 32'h1);
        chk("t2_nwrites_held", wlog_addr.size(), 32'd0);
        drain_wait("t2_drained");
        chk("t2_nwrites", wlog_addr.size(), 32'd4);
        if (wlog_addr.size() == 4) begin
            chk("t2_addr0", wlog_addr[0], 32'h100);
            chk("t2_addr3", wlog_addr[3], 32'h10C);
            chk("t2_data3", wlog_data[3], 32'h50000003);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        chk("t2_0x40_kept", ldData, 32'h0040FFBF);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        chk("t2_dropped", ldData, 32'h0200FDFF);

        // 3: forwarding picks the youngest match; misses go to memory
        do_reset();
        clear_log();
        drive(1'b1, 32'h20, 32'hAAAA0000, 1'b1, 32'h24);
        chk("t3_miss_first", ldData, 32'h0024FFDB);
        drive(1'b1, 32'h20, 32'hBBBB0000, 1'b1, 32'h20);
        chk("t3_pre_push", ldData, 32'hAAAA0000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
        chk("t3_youngest", ldData, 32'hBBBB0000);
        chk("t3_memread", 32'(memRead), 32'h1);
        chk("t3_memwrite", 32'(memWrite), 32'h0);
        chk("t3_memaddr", memAddress, 32'h20);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h24);
        chk("t3_miss", ldData, 32'h0024FFDB);
        drain_wait("t3_drained");
        chk("t3_nwrites", wlog_addr.size(), 32'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
        chk("t3_mem_final", ldData, 32'hBBBB0000);

        // 5: push every cycle while draining; occupancy stays at one
        do_reset();
        clear_log();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0, 32'h0);
            if (i > 0) begin
                chk("t5_drain", 32'(memWrite), 32'h1);
                chk("t5_not_full", 32'(bufFull), 32'h0);
            end
        end
        idle();
        chk("t5_last_drain", 32'(memWrite), 32'h1);
        idle();
        chk("t5_empty", 32'(bufEmpty), 32'h1);
        chk("t5_nwrites", wlog_addr.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog_addr.size()) begin
                chk("t5_order_addr", wlog_addr[i], 32'h300 + 32'(4 * i));
                chk("t5_order_data", wlog_data[i], 32'hC0DE0000 + 32'(i));
            end
        end

        // 4: full buffer, drain and store in the same cycle: store rejected
        do_reset();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h40400000 + 32'(i), 1'b1, 32'h40);
        end
        drive(1'b1, 32'h500, 32'h77777777, 1'b0, 32'h0);
        chk("t4_drain", 32'(memWrite), 32'h1);
        chk("t4_drain_addr", memAddress, 32'h400);
        chk("t4_full_now", 32'(bufFull), 32'h1);
        idle();
        chk("t4_overflow", 32'(errOverflow), 32'h1);
        chk("t4_not_full", 32'(bufFull), 32'h0);
        drain_wait("t4_drained");
        chk("t4_nwrites", wlog_addr.size(), 32'd4);
        begin
            int hits;
            hits = 0;
            foreach (wlog_addr[i]) if (wlog_addr[i] == 32'h500) hits++;
            chk("t4_rejected_absent", hits, 32'd0);
        end

        // 6: reset with three stores queued discards them
        clear_log();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 32'h60600000 + 32'(i), 1'b1, 32'h40);
        end
        chk("t6_ovf_pre", 32'(errOverflow), 32'h1);
        @(negedge clk);
        reset   = 1'b1;
        stWrite = 1'b0;
        ldRead  = 1'b0;
        #1;
        chk("t6_no_write_in_reset", 32'(memWrite), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_empty", 32'(bufEmpty), 32'h1);
        chk("t6_memwrite", 32'(memWrite), 32'h0);
        chk("t6_overflow", 32'(errOverflow), 32'h0);
        idle();
        idle();
        idle();
        chk("t6_nwrites", wlog_addr.size(), 32'd0);

        chk("illegal_cycles", n_illegal, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
